// File: rtl/mul_accum.sv
// Multiply-accumulate stage: sums a programmed number of unsigned products into a wider accumulator.
// Optional MUL_ACCUM_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mul_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   remaining;
  logic               ovf_q;
  logic [ACC_W:0]     sum;
  logic               take;

  // One extra bit so the carry out of the accumulator is visible as overflow.
  assign sum  = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
  assign take = (state == ACCUM) && prod_valid;

  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
        if (take && remaining == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        acc_valid = 1'b1;
        busy      = 1'b1;
        if (acc_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf_q     <= 1'b0;
            remaining <= len;
          end
        end
        ACCUM: begin
          if (take) begin
            remaining <= remaining - LEN_W'(1);
            ovf_q     <= ovf_q | sum[ACC_W];
`ifdef MUL_ACCUM_SATURATE_EN
            // Once clamped, stay clamped until the next job starts.
            if (sum[ACC_W] || ovf_q) acc <= '1;
            else                     acc <= sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_accum.sv
// Scoreboard bench for mul_accum (ACC_W=10): stimulus queues expected results, monitor checks handshakes.
module tb_mul_accum;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              busy;
  logic              ovf;

  typedef struct {int acc; int ovf;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  mul_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && acc_valid && acc_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("acc_out", int'(acc_out), e.acc);
        chk("ovf", int'(ovf), e.ovf);
      end
    end
  end

  task automatic start_job(input int l, input int exp_acc, input int exp_ovf);
    exp_t e;
    e.acc = exp_acc;
    e.ovf = exp_ovf;
    q.push_back(e);
    start = 1'b1;
    len   = LEN_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int p);
    prod       = PROD_W'(p);
    prod_valid = 1'b1;
    @(negedge clk);
    chk("prod_ready", int'(prod_ready), 1);
    @(posedge clk); #1;
    prod_valid = 1'b0;
  endtask

  // Bounded wait for acc_valid, then one acc_ready handshake.
  task automatic finish_job();
    int n = 0;
    @(negedge clk);
    while (!acc_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("acc_valid_seen", int'(acc_valid), 1);
    chk("busy_done", int'(busy), 1);
    @(posedge clk); #1;
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    @(negedge clk);
    chk("acc_valid_drop", int'(acc_valid), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ovf_exp;
    rst = 1'b1; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; acc_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_prod_ready", int'(prod_ready), 0);
    chk("rst_acc_valid", int'(acc_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_acc_out", int'(acc_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic job: 32+20+105 = 157; acc_valid right after the third handshake.
    start_job(3, 157, 0);
    send(32); send(20); send(105);
    @(negedge clk);
    chk("basic_valid_next", int'(acc_valid), 1);
    finish_job();

    // Backpressure on both sides, with ignored starts.
    start_job(2, 261, 0);
    send(225);
    start = 1'b1; len = 4'd7;
    repeat (3) begin
      @(negedge clk);
      chk("bp_wait_ready", int'(prod_ready), 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    send(36);
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(acc_valid), 1);
      chk("bp_hold_acc", int'(acc_out), 261);
      @(posedge clk); #1;
    end
    start = 1'b0;
    finish_job();

    // Zero-length job, start dropped during handshake, then len=1.
    start_job(0, 0, 0);
    @(negedge clk);
    chk("zero_valid", int'(acc_valid), 1);
    chk("zero_acc", int'(acc_out), 0);
    @(posedge clk); #1;
    acc_ready = 1'b1; start = 1'b1; len = 4'd1;
    @(posedge clk); #1;
    acc_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("dropped_start_busy", int'(busy), 0);
    chk("dropped_start_valid", int'(acc_valid), 0);
    start_job(1, 8, 0);
    send(8);
    finish_job();

    // Overflow: 15*225 = 3375 -> 303 wrapped, 1023 saturated.
`ifdef MUL_ACCUM_SATURATE_EN
    ovf_exp = 1023;
`else
    ovf_exp = 303;
`endif
    start_job(15, ovf_exp, 1);
    repeat (15) send(225);
    finish_job();
    start_job(1, 1, 0);
    send(1);
    finish_job();

    // Reset mid-job.
    start_job(5, 0, 0);
    void'(q.pop_back());
    send(3); send(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_prod_ready", int'(prod_ready), 0);
    chk("mid_rst_acc_valid", int'(acc_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_acc_out", int'(acc_out), 0);
    @(posedge clk); #1;
    start_job(1, 4, 0);
    send(4);
    finish_job();

    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
